// File: rtl/region_mem_pkg.sv
// rtl/region_mem_pkg.sv - region_mem shared types, default address map and decode helpers
// Purpose : region enum, FSM state enum, default base/depth constants, and the
//           address->region decode used by region_mem plus the map overlap check.
// Ports   : none (package)
package region_mem_pkg;

   typedef enum logic [2:0] {REG_CSR, REG_GPR, REG_TMP, REG_CON, REG_PRC, REG_NONE} region_e;
   typedef enum logic {ST_INIT, ST_RUN} state_e;

   localparam logic [31:0] DEF_CSR_BASE  = 32'hffff8000;
   localparam int          DEF_CSR_DEPTH = 4096;
   localparam logic [31:0] DEF_GPR_BASE  = 32'hffffc000;
   localparam int          DEF_GPR_DEPTH = 32;
   localparam logic [31:0] DEF_TMP_BASE  = 32'hffffc080;
   localparam int          DEF_TMP_DEPTH = 32;
   localparam logic [31:0] DEF_CON_BASE  = 32'hffffc100;
   localparam logic [31:0] DEF_PRC_BASE  = 32'hffffe000;
   localparam int          DEF_PRC_DEPTH = 2048;

   // 64-bit arithmetic so a region ending exactly at the top of the address space
   // (e.g. PRC at 0xffffe000 + 8 KiB) does not wrap.
   function automatic logic in_region(input logic [63:0] addr, input logic [63:0] base,
                                      input int words);
      return (addr >= base) && (addr < base + 64'(words) * 64'd4);
   endfunction

   function automatic logic overlap(input logic [63:0] a_base, input int a_words,
                                    input logic [63:0] b_base, input int b_words);
      return (a_base < b_base + 64'(b_words) * 64'd4) &&
             (b_base < a_base + 64'(a_words) * 64'd4);
   endfunction

   function automatic region_e decode(input logic [63:0] addr,
                                      input logic [63:0] csr_base, input int csr_words,
                                      input logic [63:0] gpr_base, input int gpr_words,
                                      input logic [63:0] tmp_base, input int tmp_words,
                                      input logic [63:0] con_base, input int con_words,
                                      input logic [63:0] prc_base, input int prc_words);
      logic [63:0] a;
      a = addr & ~64'h3;
      if (in_region(a, csr_base, csr_words)) return REG_CSR;
      if (in_region(a, gpr_base, gpr_words)) return REG_GPR;
      if (in_region(a, tmp_base, tmp_words)) return REG_TMP;
      if (in_region(a, con_base, con_words)) return REG_CON;
      if (in_region(a, prc_base, prc_words)) return REG_PRC;
      return REG_NONE;
   endfunction

endpackage

// File: rtl/region_mem_if.sv
// rtl/region_mem_if.sv - request/response bus interface for region_mem
// Purpose : groups the valid/ready request and response channels.
// Ports   : req_valid/req_ready/req_we/req_addr/req_be/req_wdata (request),
//           rsp_valid/rsp_ready/rsp_rdata/rsp_err (response).
//           master drives requests and rsp_ready; slave drives req_ready and responses.
interface region_mem_if #(
   parameter int AW = 32,
   parameter int DW = 32
);
   logic            req_valid;
   logic            req_ready;
   logic            req_we;
   logic [AW-1:0]   req_addr;
   logic [DW/8-1:0] req_be;
   logic [DW-1:0]   req_wdata;
   logic            rsp_valid;
   logic            rsp_ready;
   logic [DW-1:0]   rsp_rdata;
   logic            rsp_err;

   modport master (
      output req_valid, req_we, req_addr, req_be, req_wdata, rsp_ready,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err
   );

   modport slave (
      input  req_valid, req_we, req_addr, req_be, req_wdata, rsp_ready,
      output req_ready, rsp_valid, rsp_rdata, rsp_err
   );
endinterface

// File: rtl/region_mem_bank.sv
// rtl/region_mem_bank.sv - single-port synchronous RAM bank with byte enables
// Purpose : one storage region of region_mem; registered read, byte-lane writes.
//           Optional feature macro: REGION_MEM_PARITY_EN (even parity bit per byte).
// Ports   : clk; en (access strobe); we (1 = write); addr (word index); be (byte lanes);
//           wdata; rdata (registered, updated on reads only); perr (parity error of last read).
module region_mem_bank #(
   parameter int DEPTH = 32,
   parameter int DW    = 32,
   parameter int IW    = $clog2(DEPTH)
)(
   input  logic            clk,
   input  logic            en,
   input  logic            we,
   input  logic [IW-1:0]   addr,
   input  logic [DW/8-1:0] be,
   input  logic [DW-1:0]   wdata,
   output logic [DW-1:0]   rdata,
   output logic            perr
);
   localparam int NB = DW / 8;

   logic [DW-1:0] mem [DEPTH];

   // rdata only moves on reads so the top can hold a response while stalled.
   always_ff @(posedge clk) begin
      if (en) begin
         if (we) begin
            for (int b = 0; b < NB; b++) begin
               if (be[b]) mem[addr][8*b +: 8] <= wdata[8*b +: 8];
            end
         end else begin
            rdata <= mem[addr];
         end
      end
   end

`ifdef REGION_MEM_PARITY_EN
   logic [NB-1:0] par [DEPTH];

   function automatic logic [NB-1:0] lane_parity(input logic [DW-1:0] d);
      logic [NB-1:0] p;
      for (int b = 0; b < NB; b++) p[b] = ^d[8*b +: 8];
      return p;
   endfunction

   always_ff @(posedge clk) begin
      if (en) begin
         if (we) begin
            for (int b = 0; b < NB; b++) begin
               if (be[b]) par[addr][b] <= ^wdata[8*b +: 8];
            end
         end else begin
            perr <= |(par[addr] ^ lane_parity(mem[addr]));
         end
      end
   end
`else
   assign perr = 1'b0;
`endif

endmodule

// File: rtl/region_mem.sv
// rtl/region_mem.sv - word-addressed five-region store (CSR/GPR/TMP/CONST/PRC)
// Purpose : decodes one valid/ready bus into CSR, GPR (entry 0 reads zero), TMP,
//           generated read-only CONST and PRC regions; clears GPR/TMP after reset.
//           Optional feature macro: REGION_MEM_PARITY_EN (per-byte parity in RAM banks).
// Ports   : clk (rising edge); rst (async, active-low); bus (region_mem_if.slave);
//           init_done (clear sweep complete, block accepting requests).
module region_mem
   import region_mem_pkg::*;
#(
   parameter int            AW        = 32,
   parameter int            DW        = 32,
   parameter logic [AW-1:0] CSR_BASE  = AW'(DEF_CSR_BASE),
   parameter int            CSR_DEPTH = DEF_CSR_DEPTH,
   parameter logic [AW-1:0] GPR_BASE  = AW'(DEF_GPR_BASE),
   parameter int            GPR_DEPTH = DEF_GPR_DEPTH,
   parameter logic [AW-1:0] TMP_BASE  = AW'(DEF_TMP_BASE),
   parameter int            TMP_DEPTH = DEF_TMP_DEPTH,
   parameter logic [AW-1:0] CON_BASE  = AW'(DEF_CON_BASE),
   parameter logic [AW-1:0] PRC_BASE  = AW'(DEF_PRC_BASE),
   parameter int            PRC_DEPTH = DEF_PRC_DEPTH
)(
   input  logic        clk,
   input  logic        rst,
   region_mem_if.slave bus,
   output logic        init_done
);
   localparam int NB        = DW / 8;
   localparam int CON_DEPTH = 2 * DW;
   localparam int CSR_IW    = $clog2(CSR_DEPTH);
   localparam int GPR_IW    = $clog2(GPR_DEPTH);
   localparam int TMP_IW    = $clog2(TMP_DEPTH);
   localparam int PRC_IW    = $clog2(PRC_DEPTH);
   localparam int CON_IW    = $clog2(CON_DEPTH);
   localparam int SWEEP     = (GPR_DEPTH > TMP_DEPTH) ? GPR_DEPTH : TMP_DEPTH;
   localparam int CNT_W     = $clog2(SWEEP + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SWEEP - 1);
   localparam logic [CNT_W-1:0] GPR_LIM  = CNT_W'(GPR_DEPTH);
   localparam logic [CNT_W-1:0] TMP_LIM  = CNT_W'(TMP_DEPTH);

   localparam bit MAP_OK =
      !overlap(64'(CSR_BASE), CSR_DEPTH, 64'(GPR_BASE), GPR_DEPTH) &&
      !overlap(64'(CSR_BASE), CSR_DEPTH, 64'(TMP_BASE), TMP_DEPTH) &&
      !overlap(64'(CSR_BASE), CSR_DEPTH, 64'(CON_BASE), CON_DEPTH) &&
      !overlap(64'(CSR_BASE), CSR_DEPTH, 64'(PRC_BASE), PRC_DEPTH) &&
      !overlap(64'(GPR_BASE), GPR_DEPTH, 64'(TMP_BASE), TMP_DEPTH) &&
      !overlap(64'(GPR_BASE), GPR_DEPTH, 64'(CON_BASE), CON_DEPTH) &&
      !overlap(64'(GPR_BASE), GPR_DEPTH, 64'(PRC_BASE), PRC_DEPTH) &&
      !overlap(64'(TMP_BASE), TMP_DEPTH, 64'(CON_BASE), CON_DEPTH) &&
      !overlap(64'(TMP_BASE), TMP_DEPTH, 64'(PRC_BASE), PRC_DEPTH) &&
      !overlap(64'(CON_BASE), CON_DEPTH, 64'(PRC_BASE), PRC_DEPTH);

   if (!MAP_OK || (DW % 8) != 0) begin : g_bad_cfg
      $error("region_mem: overlapping regions or DW not a multiple of 8");
   end

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   region_e          sel;
   logic             req_ready_i, accept, dec_err, gpr_zero;
   logic [CSR_IW-1:0] csr_idx;
   logic [GPR_IW-1:0] gpr_idx, gpr_addr;
   logic [TMP_IW-1:0] tmp_idx, tmp_addr;
   logic [PRC_IW-1:0] prc_idx;
   logic [CON_IW-1:0] con_idx;
   logic [DW-1:0]     con_value;

   logic          csr_en, gpr_en, tmp_en, prc_en, bank_we;
   logic [NB-1:0] bank_be;
   logic [DW-1:0] bank_wdata;
   logic [DW-1:0] csr_rdata, gpr_rdata, tmp_rdata, prc_rdata;
   logic          csr_perr, gpr_perr, tmp_perr, prc_perr;

   logic          rsp_valid_q, rsp_rd_q, rsp_err_q;
   region_e       rsp_sel_q;
   logic [DW-1:0] con_q;
   logic [DW-1:0] rdata_mux;
   logic          perr_mux;

   assign sel = decode(64'(bus.req_addr),
                       64'(CSR_BASE), CSR_DEPTH, 64'(GPR_BASE), GPR_DEPTH,
                       64'(TMP_BASE), TMP_DEPTH, 64'(CON_BASE), CON_DEPTH,
                       64'(PRC_BASE), PRC_DEPTH);

   assign csr_idx  = CSR_IW'((bus.req_addr - CSR_BASE) >> 2);
   assign gpr_idx  = GPR_IW'((bus.req_addr - GPR_BASE) >> 2);
   assign tmp_idx  = TMP_IW'((bus.req_addr - TMP_BASE) >> 2);
   assign prc_idx  = PRC_IW'((bus.req_addr - PRC_BASE) >> 2);
   assign con_idx  = CON_IW'((bus.req_addr - CON_BASE) >> 2);
   assign gpr_zero = (gpr_idx == '0);
   assign dec_err  = (sel == REG_NONE) || (bus.req_we && sel == REG_CON);

   // One-entry output register: accept whenever the slot is empty or draining this cycle.
   assign req_ready_i = (state_q == ST_RUN) && (!rsp_valid_q || bus.rsp_ready);
   assign accept      = bus.req_valid && req_ready_i;

   // CONST: [i] = 1<<i for i < DW, [DW+i] = (1<<i)-1.
   always_comb begin
      con_value = '0;
      if (int'(con_idx) < DW) con_value = DW'(1) << con_idx;
      else                    con_value = (DW'(1) << (int'(con_idx) - DW)) - DW'(1);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= ST_INIT;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      csr_en     = 1'b0;
      gpr_en     = 1'b0;
      tmp_en     = 1'b0;
      prc_en     = 1'b0;
      bank_we    = bus.req_we;
      bank_be    = bus.req_be;
      bank_wdata = bus.req_wdata;
      gpr_addr   = gpr_idx;
      tmp_addr   = tmp_idx;
      case (state_q)
         ST_INIT: begin
            // Sweep GPR and TMP together; the shorter one simply stops early.
            bank_we    = 1'b1;
            bank_be    = '1;
            bank_wdata = '0;
            gpr_en     = (cnt_q < GPR_LIM);
            tmp_en     = (cnt_q < TMP_LIM);
            gpr_addr   = GPR_IW'(cnt_q);
            tmp_addr   = TMP_IW'(cnt_q);
            cnt_d      = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_LAST) state_d = ST_RUN;
         end
         ST_RUN: begin
            if (accept) begin
               csr_en = (sel == REG_CSR);
               gpr_en = (sel == REG_GPR) && !(bus.req_we && gpr_zero);
               tmp_en = (sel == REG_TMP);
               prc_en = (sel == REG_PRC);
            end
         end
         default: state_d = ST_INIT;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rsp_valid_q <= 1'b0;
         rsp_rd_q    <= 1'b0;
         rsp_err_q   <= 1'b0;
         rsp_sel_q   <= REG_NONE;
         con_q       <= '0;
      end else if (accept) begin
         rsp_valid_q <= 1'b1;
         rsp_err_q   <= dec_err;
         rsp_sel_q   <= sel;
         // rsp_rd_q marks responses that carry data; GPR[0] reads return zero.
         rsp_rd_q    <= !bus.req_we && (sel != REG_NONE) && !(sel == REG_GPR && gpr_zero);
         con_q       <= con_value;
      end else if (bus.rsp_ready) begin
         rsp_valid_q <= 1'b0;
         rsp_rd_q    <= 1'b0;
         rsp_err_q   <= 1'b0;
      end
   end

   always_comb begin
      rdata_mux = '0;
      perr_mux  = 1'b0;
      case (rsp_sel_q)
         REG_CSR: begin rdata_mux = csr_rdata; perr_mux = csr_perr; end
         REG_GPR: begin rdata_mux = gpr_rdata; perr_mux = gpr_perr; end
         REG_TMP: begin rdata_mux = tmp_rdata; perr_mux = tmp_perr; end
         REG_PRC: begin rdata_mux = prc_rdata; perr_mux = prc_perr; end
         REG_CON: rdata_mux = con_q;
         default: ;
      endcase
   end

   assign bus.req_ready = req_ready_i;
   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_rdata = rsp_rd_q ? rdata_mux : '0;
   assign bus.rsp_err   = rsp_err_q || (rsp_rd_q && perr_mux);
   assign init_done     = (state_q == ST_RUN);

   region_mem_bank #(.DEPTH(CSR_DEPTH), .DW(DW)) u_csr (
      .clk(clk), .en(csr_en), .we(bank_we), .addr(csr_idx), .be(bank_be),
      .wdata(bank_wdata), .rdata(csr_rdata), .perr(csr_perr));

   region_mem_bank #(.DEPTH(GPR_DEPTH), .DW(DW)) u_gpr (
      .clk(clk), .en(gpr_en), .we(bank_we), .addr(gpr_addr), .be(bank_be),
      .wdata(bank_wdata), .rdata(gpr_rdata), .perr(gpr_perr));

   region_mem_bank #(.DEPTH(TMP_DEPTH), .DW(DW)) u_tmp (
      .clk(clk), .en(tmp_en), .we(bank_we), .addr(tmp_addr), .be(bank_be),
      .wdata(bank_wdata), .rdata(tmp_rdata), .perr(tmp_perr));

   region_mem_bank #(.DEPTH(PRC_DEPTH), .DW(DW)) u_prc (
      .clk(clk), .en(prc_en), .we(bank_we), .addr(prc_idx), .be(bank_be),
      .wdata(bank_wdata), .rdata(prc_rdata), .perr(prc_perr));

endmodule

// File: tb/tb_region_mem.sv
// tb/tb_region_mem.sv - directed self-checking bench for region_mem
module tb_region_mem;
   logic clk;
   logic rst;
   logic init_done;
   int   checks = 0;
   int   passed = 0;

   region_mem_if #(.AW(32), .DW(32)) bus ();

   region_mem dut (.clk(clk), .rst(rst), .bus(bus), .init_done(init_done));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Single transaction with rsp_ready held high; drives and samples on negedges.
   task automatic xact(input logic we, input logic [31:0] addr, input logic [3:0] be,
                       input logic [31:0] wd, output logic [31:0] rd, output logic er);
      int n;
      rd = 'x;
      er = 'x;
      @(negedge clk);
      bus.req_valid = 1'b1; bus.req_we = we; bus.req_addr = addr;
      bus.req_be = be; bus.req_wdata = wd; bus.rsp_ready = 1'b1;
      n = 0;
      while (!bus.req_ready && n < 50) begin @(negedge clk); n++; end
      @(negedge clk);
      bus.req_valid = 1'b0;
      while (!bus.rsp_valid && n < 100) begin @(negedge clk); n++; end
      if (n >= 100 || !bus.rsp_valid) begin
         checks++;
         $display("FAIL xact_timeout addr=%h got no response want response", addr);
      end else begin
         rd = bus.rsp_rdata;
         er = bus.rsp_err;
      end
   endtask

   task automatic test_reset();
      int n;
      logic [31:0] rd;
      logic er;
      rst = 1'b0;
      bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_addr = '0;
      bus.req_be = '0; bus.req_wdata = '0; bus.rsp_ready = 1'b0;
      repeat (3) @(negedge clk);
      checks++; if (bus.req_ready !== 1'b0) $display("FAIL rst_req_ready got %b want 0", bus.req_ready); else passed++;
      checks++; if (bus.rsp_valid !== 1'b0) $display("FAIL rst_rsp_valid got %b want 0", bus.rsp_valid); else passed++;
      checks++; if (bus.rsp_rdata !== 32'h0) $display("FAIL rst_rsp_rdata got %h want 0", bus.rsp_rdata); else passed++;
      checks++; if (bus.rsp_err !== 1'b0) $display("FAIL rst_rsp_err got %b want 0", bus.rsp_err); else passed++;
      checks++; if (init_done !== 1'b0) $display("FAIL rst_init_done got %b want 0", init_done); else passed++;
      rst = 1'b1;
      n = 0;
      while (!init_done && n < 100) begin @(negedge clk); n++; end
      checks++; if (n != 32) $display("FAIL init_cycles got %0d want 32", n); else passed++;
      checks++; if (bus.req_ready !== 1'b1) $display("FAIL run_req_ready got %b want 1", bus.req_ready); else passed++;
      xact(1'b0, 32'hffffc014, 4'h0, 32'h0, rd, er);
      checks++; if (rd !== 32'h0 || er !== 1'b0) $display("FAIL gpr5_after_init got %h/%b want 00000000/0", rd, er); else passed++;
   endtask

   task automatic test_byte_enables();
      logic [31:0] rd;
      logic er;
      xact(1'b1, 32'hffff8010, 4'hf, 32'h11223344, rd, er);
      checks++; if (rd !== 32'h0 || er !== 1'b0) $display("FAIL wr_rsp got %h/%b want 00000000/0", rd, er); else passed++;
      xact(1'b0, 32'hffff8010, 4'h0, 32'h0, rd, er);
      checks++; if (rd !== 32'h11223344) $display("FAIL csr_full got %h want 11223344", rd); else passed++;
      xact(1'b1, 32'hffff8010, 4'b0101, 32'hdeadbeef, rd, er);
      xact(1'b0, 32'hffff8010, 4'h0, 32'h0, rd, er);
      checks++; if (rd !== 32'h11ad33ef || er !== 1'b0) $display("FAIL csr_be0101 got %h/%b want 11ad33ef/0", rd, er); else passed++;
      xact(1'b1, 32'hffff8010, 4'h0, 32'hffffffff, rd, er);
      checks++; if (er !== 1'b0) $display("FAIL be0_err got %b want 0", er); else passed++;
      xact(1'b0, 32'hffff8010, 4'h0, 32'h0, rd, er);
      checks++; if (rd !== 32'h11ad33ef) $display("FAIL be0_noop got %h want 11ad33ef", rd); else passed++;
      xact(1'b1, 32'hffffbffc, 4'hf, 32'h600dcafe, rd, er);
      xact(1'b0, 32'hffffbffd, 4'h0, 32'h0, rd, er);
      checks++; if (rd !== 32'h600dcafe || er !== 1'b0) $display("FAIL csr_last got %h/%b want 600dcafe/0", rd, er); else passed++;
   endtask

   task automatic test_gpr0_const();
      logic [31:0] rd;
      logic er;
      xact(1'b1, 32'hffffc000, 4'hf, 32'h00000055, rd, er);
      checks++; if (er !== 1'b0) $display("FAIL gpr0_wr_err got %b want 0", er); else passed++;
      xact(1'b0, 32'hffffc000, 4'h0, 32'h0, rd, er);
      checks++; if (rd !== 32'h0 || er !== 1'b0) $display("FAIL gpr0_rd got %h/%b want 00000000/0", rd, er); else passed++;
      xact(1'b1, 32'hffffc004, 4'hf, 32'ha5a5a5a5, rd, er);
      xact(1'b0, 32'hffffc004, 4'h0, 32'h0, rd, er);
      checks++; if (rd !== 32'ha5a5a5a5) $display("FAIL gpr1 got %h want a5a5a5a5", rd); else passed++;
      xact(1'b0, 32'hffffc100, 4'h0, 32'h0, rd, er);
      checks++; if (rd !== 32'h00000001 || er !== 1'b0) $display("FAIL con0 got %h/%b want 00000001/0", rd, er); else passed++;
      xact(1'b0, 32'hffffc17c, 4'h0, 32'h0, rd, er);
      checks++; if (rd !== 32'h80000000) $display("FAIL con31 got %h want 80000000", rd); else passed++;
      xact(1'b0, 32'hffffc180, 4'h0, 32'h0, rd, er);
      checks++; if (rd !== 32'h00000000 || er !== 1'b0) $display("FAIL con32 got %h/%b want 00000000/0", rd, er); else passed++;
      xact(1'b0, 32'hffffc1a4, 4'h0, 32'h0, rd, er);
      checks++; if (rd !== 32'h000001ff) $display("FAIL con41 got %h want 000001ff", rd); else passed++;
      xact(1'b0, 32'hffffc1fc, 4'h0, 32'h0, rd, er);
      checks++; if (rd !== 32'h7fffffff) $display("FAIL con63 got %h want 7fffffff", rd); else passed++;
   endtask

   task automatic test_errors();
      logic [31:0] rd;
      logic er;
      xact(1'b1, 32'hffffc100, 4'hf, 32'h12345678, rd, er);
      checks++; if (rd !== 32'h0 || er !== 1'b1) $display("FAIL con_wr got %h/%b want 00000000/1", rd, er); else passed++;
      xact(1'b0, 32'hffffc100, 4'h0, 32'h0, rd, er);
      checks++; if (rd !== 32'h00000001) $display("FAIL con_after_wr got %h want 00000001", rd); else passed++;
      xact(1'b0, 32'h00001000, 4'h0, 32'h0, rd, er);
      checks++; if (rd !== 32'h0 || er !== 1'b1) $display("FAIL unmapped got %h/%b want 00000000/1", rd, er); else passed++;
      xact(1'b0, 32'hffff7ffc, 4'h0, 32'h0, rd, er);
      checks++; if (er !== 1'b1) $display("FAIL below_csr got %b want 1", er); else passed++;
      xact(1'b1, 32'hffffc200, 4'hf, 32'hffffffff, rd, er);
      checks++; if (er !== 1'b1) $display("FAIL gap_wr got %b want 1", er); else passed++;
      xact(1'b1, 32'hfffffffc, 4'hf, 32'h0badf00d, rd, er);
      xact(1'b0, 32'hfffffffc, 4'h0, 32'h0, rd, er);
      checks++; if (rd !== 32'h0badf00d || er !== 1'b0) $display("FAIL prc_last got %h/%b want 0badf00d/0", rd, er); else passed++;
      xact(1'b1, 32'hffffc0fc, 4'hf, 32'h5a5a0001, rd, er);
      xact(1'b0, 32'hffffc0fc, 4'h0, 32'h0, rd, er);
      checks++; if (rd !== 32'h5a5a0001) $display("FAIL tmp_last got %h want 5a5a0001", rd); else passed++;
   endtask

   task automatic test_back_to_back();
      logic [31:0] exp_q [10];
      logic [31:0] rd;
      logic er;
      int sent, recv, c;
      for (int i = 0; i < 10; i++) begin
         exp_q[i] = 32'h10000000 + 32'(i) * 32'h01010101;
         xact(1'b1, 32'hffffc080 + 32'(4 * i), 4'hf, exp_q[i], rd, er);
      end
      sent = 0; recv = 0; c = 0;
      while (recv < 10 && c < 100) begin
         @(negedge clk);
         bus.rsp_ready = (c % 2 == 0);
         bus.req_valid = (sent < 10);
         bus.req_we    = 1'b0;
         bus.req_be    = '0;
         bus.req_addr  = 32'hffffc080 + 32'(4 * sent);
         #1;
         checks++; if (bus.req_ready !== !(bus.rsp_valid && !bus.rsp_ready)) $display("FAIL b2b_req_ready cyc %0d got %b want %b", c, bus.req_ready, !(bus.rsp_valid && !bus.rsp_ready)); else passed++;
         if (bus.rsp_valid && bus.rsp_ready) begin
            checks++; if (bus.rsp_rdata !== exp_q[recv] || bus.rsp_err !== 1'b0) $display("FAIL b2b_data idx %0d got %h/%b want %h/0", recv, bus.rsp_rdata, bus.rsp_err, exp_q[recv]); else passed++;
            recv++;
         end
         if (bus.req_valid && bus.req_ready) sent++;
         c++;
      end
      bus.req_valid = 1'b0;
      bus.rsp_ready = 1'b1;
      checks++; if (recv != 10) $display("FAIL b2b_count got %0d want 10", recv); else passed++;
      @(negedge clk);
      checks++; if (bus.rsp_valid !== 1'b0) $display("FAIL b2b_extra got %b want 0", bus.rsp_valid); else passed++;
   endtask

   task automatic test_raw();
      @(negedge clk);
      bus.rsp_ready = 1'b1;
      bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_addr = 32'hffffc0d0;
      bus.req_be = 4'hf; bus.req_wdata = 32'hfeedface;
      @(negedge clk);
      checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_rdata !== 32'h0) $display("FAIL raw_wr_rsp got %b/%h want 1/00000000", bus.rsp_valid, bus.rsp_rdata); else passed++;
      bus.req_we = 1'b0;
      @(negedge clk);
      bus.req_valid = 1'b0;
      checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_rdata !== 32'hfeedface) $display("FAIL raw_rd got %b/%h want 1/feedface", bus.rsp_valid, bus.rsp_rdata); else passed++;
      @(negedge clk);
   endtask

   task automatic test_reset_mid();
      int n;
      logic [31:0] rd;
      logic er;
      xact(1'b1, 32'hffffc014, 4'hf, 32'h12345678, rd, er);
      xact(1'b1, 32'hffffc09c, 4'hf, 32'hcafef00d, rd, er);
      @(negedge clk);
      bus.rsp_ready = 1'b0;
      bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_addr = 32'hffffc014;
      @(negedge clk);
      bus.req_valid = 1'b0;
      checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_rdata !== 32'h12345678) $display("FAIL pend_rsp got %b/%h want 1/12345678", bus.rsp_valid, bus.rsp_rdata); else passed++;
      rst = 1'b0;
      #1;
      checks++; if (bus.rsp_valid !== 1'b0 || bus.rsp_rdata !== 32'h0) $display("FAIL mid_rst_drop got %b/%h want 0/00000000", bus.rsp_valid, bus.rsp_rdata); else passed++;
      checks++; if (init_done !== 1'b0 || bus.req_ready !== 1'b0) $display("FAIL mid_rst_state got %b/%b want 0/0", init_done, bus.req_ready); else passed++;
      @(negedge clk);
      rst = 1'b1;
      repeat (10) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      n = 0;
      while (!init_done && n < 100) begin @(negedge clk); n++; end
      checks++; if (n != 32) $display("FAIL restart_cycles got %0d want 32", n); else passed++;
      xact(1'b0, 32'hffffc014, 4'h0, 32'h0, rd, er);
      checks++; if (rd !== 32'h0) $display("FAIL gpr5_cleared got %h want 00000000", rd); else passed++;
      xact(1'b0, 32'hffffc09c, 4'h0, 32'h0, rd, er);
      checks++; if (rd !== 32'h0) $display("FAIL tmp7_cleared got %h want 00000000", rd); else passed++;
      xact(1'b0, 32'hffff8010, 4'h0, 32'h0, rd, er);
      checks++; if (rd !== 32'h11ad33ef) $display("FAIL csr_kept got %h want 11ad33ef", rd); else passed++;
   endtask

`ifdef REGION_MEM_PARITY_EN
   task automatic test_parity();
      logic [31:0] rd;
      logic er;
      xact(1'b1, 32'hffffe00c, 4'hf, 32'h0f0f0f0f, rd, er);
      xact(1'b0, 32'hffffe00c, 4'h0, 32'h0, rd, er);
      checks++; if (rd !== 32'h0f0f0f0f || er !== 1'b0) $display("FAIL par_clean got %h/%b want 0f0f0f0f/0", rd, er); else passed++;
      dut.u_prc.mem[3][0] = ~dut.u_prc.mem[3][0];
      xact(1'b0, 32'hffffe00c, 4'h0, 32'h0, rd, er);
      checks++; if (rd !== 32'h0f0f0f0e || er !== 1'b1) $display("FAIL par_flip got %h/%b want 0f0f0f0e/1", rd, er); else passed++;
   endtask
`endif

   initial begin
      test_reset();
      test_byte_enables();
      test_gpr0_const();
      test_errors();
      test_back_to_back();
      test_raw();
      test_reset_mid();
`ifdef REGION_MEM_PARITY_EN
      test_parity();
`endif
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog got no finish want finish");
      $fatal(1, "watchdog");
   end
endmodule
